i2c_slave_ram_responder: RTL and testbench

I2C_SLAVE_RAM_RESPONDER -- requirements
Module: i2c_slave_ram_responder

---
 rtl/i2c_slave_ram_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_slave_ram_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ram_responder.sv
// I2C slave fronting a 32-byte register RAM: pointer write, burst write, burst read.
// Bus pins are oversampled by clk; the slave only changes SDA while SCL is low.
module i2c_slave_ram_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_OE,
  input  logic [6:0] SlaveAddr,
  output logic [4:0] RAM_ADD,
  output logic [7:0] RAM_DIN,
  output logic       RAM_W,
  input  logic [7:0] RAM_RDOUT,
  output logic       Slave_Busy,
  output logic       Slave_Done,
  output logic [3:0] o_dbg_state
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  logic [SS-1:0] r_scl_sync;
  logic [SS-1:0] r_sda_sync;
  logic          r_scl_d;
  logic          r_sda_d;

  state_t     r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_sda_oe;
  logic [4:0] r_ram_add;
  logic [7:0] r_ram_din;
  logic       r_ram_w;
  logic       r_busy;
  logic       r_done;

  state_t     w_state_nxt;
  logic [3:0] w_bitcnt_nxt;
  logic [7:0] w_shift_nxt;
  logic       w_rw_nxt;
  logic       w_sda_oe_nxt;
  logic [4:0] w_ram_add_nxt;
  logic [7:0] w_ram_din_nxt;
  logic       w_ram_w_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_byte_in;

  // Synchronizers and history flops idle at 1 so reset never fakes a bus event.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SS-2:0], SCL_in};
      r_sda_sync <= {r_sda_sync[SS-2:0], SDA_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SS-1];
  assign w_sda      = r_sda_sync[SS-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte_in  = w_scl_fall && (r_bitcnt == 4'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'd0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_ram_add <= 5'd0;
      r_ram_din <= 8'd0;
      r_ram_w   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rw      <= w_rw_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_ram_add <= w_ram_add_nxt;
      r_ram_din <= w_ram_din_nxt;
      r_ram_w   <= w_ram_w_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_rw_nxt      = r_rw;
    w_sda_oe_nxt  = r_sda_oe;
    // The pointer advances the clk after each write strobe.
    w_ram_add_nxt = r_ram_w ? r_ram_add + 5'd1 : r_ram_add;
    w_ram_din_nxt = r_ram_din;
    w_ram_w_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_done_nxt   = r_busy;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: ;
        S_ADDR, S_REG, S_WDATA: begin
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_byte_in) begin
            w_bitcnt_nxt = 4'd0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == SlaveAddr) begin
                w_sda_oe_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
                w_rw_nxt     = r_shift[0];
                w_state_nxt  = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else if (r_state == S_REG) begin
              w_sda_oe_nxt  = 1'b1;
              w_ram_add_nxt = r_shift[4:0];
              w_state_nxt   = S_REG_ACK;
            end else begin
              w_sda_oe_nxt  = 1'b1;
              w_ram_din_nxt = r_shift;
              w_ram_w_nxt   = 1'b1;
              w_state_nxt   = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt_nxt = 4'd0;
            if (r_rw) begin
              w_shift_nxt  = RAM_RDOUT;
              w_sda_oe_nxt = ~RAM_RDOUT[7];
              w_state_nxt  = S_RDATA;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = S_REG;
            end
          end
        end
        S_REG_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_WDATA;
          end
        end
        S_RDATA: begin
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_byte_in) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_RDATA_ACK;
          end else if (w_scl_fall) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        S_RDATA_ACK: begin
          // A fall here always follows an ACK; a NACK has already left the state.
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ram_add_nxt = r_ram_add + 5'd1;
            end else begin
              w_state_nxt  = S_IDLE;
              w_busy_nxt   = 1'b0;
              w_sda_oe_nxt = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_shift_nxt  = RAM_RDOUT;
            w_sda_oe_nxt = ~RAM_RDOUT[7];
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_RDATA;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign SDA_OE      = r_sda_oe & ~reset;
  assign RAM_ADD     = r_ram_add;
  assign RAM_DIN     = r_ram_din;
  assign RAM_W       = r_ram_w;
  assign Slave_Busy  = r_busy;
  assign Slave_Done  = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_slave_ram_responder.sv
// Directed bench for i2c_slave_ram_responder: bit-banged I2C master, open-drain SDA,
// RAM model returning k+0x10 at address k, and a write scoreboard.
module tb_i2c_slave_ram_responder;

  localparam int Q = 8;
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic [6:0] slave_addr = 7'h42;
  logic       sda_oe;
  logic [4:0] ram_add;
  logic [7:0] ram_din;
  logic       ram_w;
  logic [7:0] ram_rdout;
  logic       busy;
  logic       done;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [12:0] wr_q[$];
  logic [12:0] exp_q[$];
  int done_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  assign sda_line  = sda_m & ~sda_oe;
  assign ram_rdout = 8'h10 + {3'b000, ram_add};

  i2c_slave_ram_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .SCL_in     (scl),
    .SDA_in     (sda_line),
    .SDA_OE     (sda_oe),
    .SlaveAddr  (slave_addr),
    .RAM_ADD    (ram_add),
    .RAM_DIN    (ram_din),
    .RAM_W      (ram_w),
    .RAM_RDOUT  (ram_rdout),
    .Slave_Busy (busy),
    .Slave_Done (done),
    .o_dbg_state(dbg_state)
  );

  always @(posedge clk) begin
    if (ram_w) wr_q.push_back({ram_add, ram_din});
    if (done) done_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end

  // ---------------- master driver tasks ----------------
  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    sda_m = 1'b0; qw();
    scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl = 1'b1; qw();
    sda_m = 1'b1; qw(); qw();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qw();
    scl = 1'b1; qw(); qw();
    scl = 1'b0; qw();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qw();
    scl = 1'b1; qw();
    b = sda_line; qw();
    scl = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = ~b;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~m_ack);
  endtask

  task automatic check_writes(input string name, input int base);
    checks++;
    if (wr_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s write %0d: got add=%0d din=%h expected add=%0d din=%h", name, i,
                   wr_q[base + i][12:8], wr_q[base + i][7:0], exp_q[i][12:8], exp_q[i][7:0]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset SDA_OE: got %b expected 0", sda_oe); end
    checks++; if (ram_w !== 1'b0) begin errors++; $display("FAIL reset RAM_W: got %b expected 0", ram_w); end
    checks++; if (ram_add !== 5'd0) begin errors++; $display("FAIL reset RAM_ADD: got %0d expected 0", ram_add); end
    checks++; if (ram_din !== 8'h00) begin errors++; $display("FAIL reset RAM_DIN: got %h expected 00", ram_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset Slave_Busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset Slave_Done: got %b expected 0", done); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_basic_write();
    int base = wr_q.size();
    int dbase = done_cnt;
    logic [3:0] acks;
    logic busy_mid;
    exp_q.delete();
    exp_q.push_back({5'd5, 8'hA5});
    exp_q.push_back({5'd6, 8'h3C});
    i2c_start();
    write_byte(8'h84, acks[3]);
    busy_mid = busy;
    write_byte(8'h05, acks[2]);
    write_byte(8'hA5, acks[1]);
    write_byte(8'h3C, acks[0]);
    i2c_stop();
    checks++; if (acks !== 4'hF) begin errors++; $display("FAIL basic acks: got %b expected 1111", acks); end
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic busy after addr: got %b expected 1", busy_mid); end
    check_writes("basic", base);
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL basic done pulses: got %0d expected 1", done_cnt - dbase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic busy after stop: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    int base = wr_q.size();
    logic [4:0] acks;
    exp_q.delete();
    exp_q.push_back({5'd31, 8'hDE});
    exp_q.push_back({5'd0, 8'hAD});
    exp_q.push_back({5'd1, 8'hBE});
    i2c_start();
    write_byte(8'h84, acks[4]);
    write_byte(8'h1F, acks[3]);
    write_byte(8'hDE, acks[2]);
    write_byte(8'hAD, acks[1]);
    write_byte(8'hBE, acks[0]);
    i2c_stop();
    checks++; if (acks !== 5'h1F) begin errors++; $display("FAIL wrap acks: got %b expected 11111", acks); end
    check_writes("wrap", base);
    checks++; if (ram_add !== 5'd2) begin errors++; $display("FAIL wrap final RAM_ADD: got %0d expected 2", ram_add); end
  endtask

  task automatic test_read();
    int base = wr_q.size();
    int dbase = done_cnt;
    logic [2:0] acks;
    logic [7:0] d0, d1, d2;
    exp_q.delete();
    i2c_start();
    write_byte(8'h84, acks[2]);
    write_byte(8'h03, acks[1]);
    i2c_start();
    write_byte(8'h85, acks[0]);
    read_byte(1'b1, d0);
    read_byte(1'b1, d1);
    read_byte(1'b0, d2);
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL read acks: got %b expected 111", acks); end
    checks++; if (d0 !== 8'h13) begin errors++; $display("FAIL read byte0: got %h expected 13", d0); end
    checks++; if (d1 !== 8'h14) begin errors++; $display("FAIL read byte1: got %h expected 14", d1); end
    checks++; if (d2 !== 8'h15) begin errors++; $display("FAIL read byte2: got %h expected 15", d2); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL read state after nack: got %0d expected 0", dbg_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read busy after nack: got %b expected 0", busy); end
    checks++; if (ram_add !== 5'd5) begin errors++; $display("FAIL read final RAM_ADD: got %0d expected 5", ram_add); end
    i2c_stop();
    checks++; if (done_cnt != dbase) begin errors++; $display("FAIL read done after nack stop: got %0d expected 0", done_cnt - dbase); end
    check_writes("read", base);
  endtask

  task automatic test_wrong_addr();
    int base = wr_q.size();
    int obase = oe_cnt;
    int bbase = busy_cnt;
    logic [1:0] acks;
    exp_q.delete();
    i2c_start();
    write_byte(8'h90, acks[1]);
    write_byte(8'h05, acks[0]);
    i2c_stop();
    checks++; if (acks !== 2'b00) begin errors++; $display("FAIL wrong_addr acks: got %b expected 00", acks); end
    checks++; if (oe_cnt != obase) begin errors++; $display("FAIL wrong_addr SDA_OE cycles: got %0d expected 0", oe_cnt - obase); end
    checks++; if (busy_cnt != bbase) begin errors++; $display("FAIL wrong_addr busy cycles: got %0d expected 0", busy_cnt - bbase); end
    check_writes("wrong_addr", base);
  endtask

  task automatic test_reset_mid();
    int base = wr_q.size();
    int dbase = done_cnt;
    logic [1:0] pre;
    logic [2:0] acks;
    exp_q.delete();
    i2c_start();
    write_byte(8'h84, pre[1]);
    write_byte(8'h08, pre[0]);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    sda_m = 1'b1; qw();
    scl = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy before reset: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_mid SDA_OE: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_mid state: got %0d expected 0", dbg_state); end
    qw();
    scl = 1'b0; qw();
    write_bit(1'b1);
    i2c_stop();
    check_writes("reset_mid aborted", base);
    checks++; if (done_cnt != dbase) begin errors++; $display("FAIL reset_mid done pulses: got %0d expected 0", done_cnt - dbase); end
    base = wr_q.size();
    dbase = done_cnt;
    exp_q.push_back({5'd10, 8'h77});
    i2c_start();
    write_byte(8'h84, acks[2]);
    write_byte(8'h0A, acks[1]);
    write_byte(8'h77, acks[0]);
    i2c_stop();
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL reset_mid recovery acks: got %b expected 111", acks); end
    check_writes("reset_mid recovery", base);
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL reset_mid recovery done: got %0d expected 1", done_cnt - dbase); end
  endtask

  task automatic test_stop_mid();
    int base = wr_q.size();
    int dbase = done_cnt;
    logic [1:0] acks;
    logic [7:0] d = 8'hC3;
    exp_q.delete();
    i2c_start();
    write_byte(8'h84, acks[1]);
    write_byte(8'h10, acks[0]);
    for (int i = 7; i >= 3; i--) write_bit(d[i]);
    i2c_stop();
    checks++; if (acks !== 2'b11) begin errors++; $display("FAIL stop_mid acks: got %b expected 11", acks); end
    check_writes("stop_mid", base);
    checks++; if (done_cnt - dbase != 1) begin errors++; $display("FAIL stop_mid done pulses: got %0d expected 1", done_cnt - dbase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_mid busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrap();
    test_read();
    test_wrong_addr();
    test_reset_mid();
    test_stop_mid();
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
